// File: rtl/packet_rr_arbiter.sv
// Packet-granular round-robin arbiter: holds a registered one-hot grant until the
// granted packet's last beat (or an idle watchdog expiry), then rotates priority.
module packet_rr_arbiter #(
   parameter int SIZE = 4,
   parameter int TIMEOUT = 0,
   localparam int IDX_W = $clog2(SIZE)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic [SIZE-1:0]  req,
   input  logic             beat,
   input  logic             last,
   output logic [SIZE-1:0]  grant,
   output logic [IDX_W-1:0] grant_idx,
   output logic             grant_valid,
   output logic             timeout
);

   typedef enum logic {IDLE, BUSY} state_t;

   localparam logic [15:0] TO_VAL = 16'(TIMEOUT);

   state_t           state_reg, state_next;
   logic [SIZE-1:0]  grant_reg, grant_next;
   logic [IDX_W-1:0] idx_reg, idx_next;
   logic             valid_reg, valid_next;
   logic [IDX_W-1:0] ptr_reg, ptr_next;
   logic [15:0]      cnt_reg, cnt_next;
   logic             timeout_reg, timeout_next;

   logic [2*SIZE-1:0] req_dbl;
   logic [2*SIZE-1:0] req_rot;
   logic [IDX_W-1:0]  sel_off;
   logic [IDX_W-1:0]  sel_idx;
   logic              any_req;
   logic              expire;
   logic              release_now;
   logic              take_grant;

   // Rotate the request vector so ptr lands at bit 0; the lowest set bit is the winner.
   assign req_dbl = {req, req};
   assign req_rot = req_dbl >> ptr_reg;
   assign any_req = |req;

   always_comb begin
      sel_off = '0;
      for (int i = SIZE - 1; i >= 0; i--) begin
         if (req_rot[i]) sel_off = IDX_W'(i);
      end
   end

   assign sel_idx = ptr_reg + sel_off;
   assign expire  = (TIMEOUT != 0) && (cnt_reg == TO_VAL - 16'd1);

   always_comb begin
      state_next   = state_reg;
      idx_next     = idx_reg;
      valid_next   = valid_reg;
      ptr_next     = ptr_reg;
      cnt_next     = cnt_reg;
      timeout_next = 1'b0;
      release_now  = 1'b0;
      take_grant   = 1'b0;
      grant_next   = '0;

      case (state_reg)
         IDLE: begin
            cnt_next   = '0;
            take_grant = any_req;
         end
         BUSY: begin
            if (beat && last) begin
               release_now = 1'b1;
            end else if (beat) begin
               cnt_next = '0;
            end else if (expire) begin
               release_now  = 1'b1;
               timeout_next = 1'b1;
            end else if (TIMEOUT != 0) begin
               cnt_next = cnt_reg + 16'd1;
            end

            if (release_now) begin
               cnt_next = '0;
               if (any_req) begin
                  take_grant = 1'b1;
               end else begin
                  state_next = IDLE;
                  valid_next = 1'b0;
                  idx_next   = '0;
               end
            end
         end
         default: state_next = IDLE;
      endcase

      // ptr already points one past the previous owner, so the served requester is last in line.
      if (take_grant) begin
         state_next = BUSY;
         idx_next   = sel_idx;
         valid_next = 1'b1;
         ptr_next   = sel_idx + IDX_W'(1);
      end

      grant_next[idx_next] = valid_next;
   end

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         state_reg   <= IDLE;
         grant_reg   <= '0;
         idx_reg     <= '0;
         valid_reg   <= 1'b0;
         ptr_reg     <= '0;
         cnt_reg     <= '0;
         timeout_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         grant_reg   <= grant_next;
         idx_reg     <= idx_next;
         valid_reg   <= valid_next;
         ptr_reg     <= ptr_next;
         cnt_reg     <= cnt_next;
         timeout_reg <= timeout_next;
      end
   end

   assign grant       = grant_reg;
   assign grant_idx   = idx_reg;
   assign grant_valid = valid_reg;
   assign timeout     = timeout_reg;

endmodule

// File: tb/tb_packet_rr_arbiter.sv
// Bench for packet_rr_arbiter: directed scenarios then random traffic, all checked
// against a queue-free behavioural model of owner/priority/idle-count.
module tb_packet_rr_arbiter;

   localparam int SIZE = 4;
   localparam int IDX_W = 2;
   localparam int TIMEOUT = 8;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             clear = 1'b0;
   logic [SIZE-1:0]  req = '0;
   logic             beat = 1'b0;
   logic             last = 1'b0;
   logic [SIZE-1:0]  grant;
   logic [IDX_W-1:0] grant_idx;
   logic             grant_valid;
   logic             timeout;

   int checks = 0;
   int errors = 0;

   // Behavioural reference state
   int m_owner = 0;
   bit m_busy = 0;
   int m_ptr = 0;
   int m_idle = 0;
   bit m_to = 0;

   packet_rr_arbiter #(.SIZE(SIZE), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset), .clear(clear), .req(req), .beat(beat), .last(last),
      .grant(grant), .grant_idx(grant_idx), .grant_valid(grant_valid), .timeout(timeout)
   );

   always #5 clk = ~clk;

   function automatic int pick(input logic [SIZE-1:0] r, input int p);
      for (int i = 0; i < SIZE; i++) begin
         if (r[(p + i) % SIZE]) return (p + i) % SIZE;
      end
      return -1;
   endfunction

   task automatic model_update(input logic [SIZE-1:0] r, input bit b, input bit l,
                               input bit rs, input bit cl);
      bit done_pkt;
      int k;
      m_to = 0;
      if (rs || cl) begin
         m_busy = 0; m_owner = 0; m_ptr = 0; m_idle = 0;
         return;
      end
      done_pkt = 0;
      if (!m_busy) begin
         m_idle = 0;
         done_pkt = 1;
      end else if (b && l) begin
         done_pkt = 1;
      end else if (b) begin
         m_idle = 0;
      end else if (TIMEOUT > 0) begin
         m_idle++;
         if (m_idle == TIMEOUT) begin
            done_pkt = 1;
            m_to = 1;
         end
      end
      if (done_pkt) begin
         m_idle = 0;
         k = pick(r, m_ptr);
         if (k >= 0) begin
            m_busy = 1; m_owner = k; m_ptr = (k + 1) % SIZE;
         end else begin
            m_busy = 0; m_owner = 0;
         end
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic compare_model(input string tag);
      logic [SIZE-1:0] exp_grant;
      exp_grant = '0;
      if (m_busy) exp_grant[m_owner] = 1'b1;
      check({tag, ".grant"}, 32'(grant), 32'(exp_grant));
      check({tag, ".idx"}, 32'(grant_idx), m_busy ? 32'(m_owner) : 32'd0);
      check({tag, ".valid"}, 32'(grant_valid), 32'(m_busy));
      check({tag, ".timeout"}, 32'(timeout), 32'(m_to));
   endtask

   // One clock: drive inputs, advance the model on the edge, compare 1 time unit later.
   task automatic step(input string tag, input logic [SIZE-1:0] r, input bit b, input bit l,
                       input bit rs = 0, input bit cl = 0);
      req = r; beat = b; last = l; reset = rs; clear = cl;
      @(posedge clk);
      model_update(r, b, l, rs, cl);
      #1;
      compare_model(tag);
      $display("step %-8s req=%b beat=%0b last=%0b rst=%0b clr=%0b -> grant=%b idx=%0d valid=%0b to=%0b",
               tag, r, b, l, rs, cl, grant, grant_idx, grant_valid, timeout);
   endtask

   initial begin
      int bprob;
      // Reset held with all requests pending
      for (int i = 0; i < 3; i++) begin
         step("reset", 4'b1111, 0, 0, 1, 0);
         check("reset.grant", 32'(grant), 32'd0);
      end
      step("rel", 4'b1111, 0, 0);
      check("rel.grant", 32'(grant), 32'h1);

      // Back-to-back single-beat packets rotate 1,2,3,0
      for (int i = 1; i <= 4; i++) begin
         step("rot", 4'b1111, 1, 1);
         check("rot.idx", 32'(grant_idx), 32'(i % SIZE));
         check("rot.valid", 32'(grant_valid), 32'd1);
      end

      // Serve 1 then 2 so ptr=3, then wrap to 0 and re-grant lone requester 0
      step("pre", 4'b1111, 1, 1);
      step("pre", 4'b1111, 1, 1);
      check("pre.idx", 32'(grant_idx), 32'd2);
      step("wrap", 4'b0011, 1, 1);
      check("wrap.idx", 32'(grant_idx), 32'd0);
      step("regrant", 4'b0001, 1, 1);
      check("regrant.idx", 32'(grant_idx), 32'd0);
      check("regrant.valid", 32'(grant_valid), 32'd1);

      // Frozen grant over a 5-beat packet on requester 1
      step("fz.get", 4'b0010, 1, 1);
      check("fz.get", 32'(grant), 32'h2);
      step("fz.b1", 4'b0100, 1, 0);
      step("fz.lnb", 4'b0100, 0, 1);
      step("fz.b2", 4'b0110, 1, 0);
      step("fz.idle", 4'b0100, 0, 0);
      step("fz.b3", 4'b0100, 1, 0);
      step("fz.b4", 4'b0100, 1, 0);
      check("fz.hold", 32'(grant), 32'h2);
      step("fz.b5", 4'b0100, 1, 1);
      check("fz.next", 32'(grant), 32'h4);

      // Watchdog: grant on 2, no beats, release to IDLE on the 8th cycle
      for (int i = 1; i <= 8; i++) begin
         step("wd", 4'b0000, 0, 0);
         check("wd.pulse", 32'(timeout), (i == 8) ? 32'd1 : 32'd0);
      end
      check("wd.idle", 32'(grant_valid), 32'd0);

      // Watchdog restart by a beat at cycle 7, then re-grant coinciding with the pulse
      step("wd2.get", 4'b0010, 0, 0);
      check("wd2.get", 32'(grant_idx), 32'd1);
      for (int i = 1; i <= 6; i++) step("wd2", 4'b0010, 0, 0);
      step("wd2.beat", 4'b0010, 1, 0);
      for (int i = 1; i <= 8; i++) begin
         step("wd2", 4'b0010, 0, 0);
         check("wd2.pulse", 32'(timeout), (i == 8) ? 32'd1 : 32'd0);
      end
      check("wd2.regrant", 32'(grant), 32'h2);
      step("wd2.after", 4'b0010, 1, 1);
      check("wd2.after", 32'(timeout), 32'd0);

      // Clear during beat 2 of a packet on requester 3
      step("cl.get", 4'b1000, 1, 1);
      check("cl.get", 32'(grant_idx), 32'd3);
      step("cl.b1", 4'b1000, 1, 0);
      step("cl.b2", 4'b1000, 1, 0, 0, 1);
      check("cl.idle", 32'(grant_valid), 32'd0);
      step("cl.reget", 4'b1000, 0, 0);
      check("cl.reget", 32'(grant_idx), 32'd3);

      // Random traffic with varying beat density so the watchdog also fires
      for (int n = 0; n < 3000; n++) begin
         bprob = (n < 1000) ? 70 : ((n < 2000) ? 10 : 40);
         step("rnd", 4'($urandom_range(0, 15)),
              $urandom_range(0, 99) < bprob,
              $urandom_range(0, 2) == 0,
              $urandom_range(0, 299) == 0,
              $urandom_range(0, 299) == 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/packet_rr_arbiter.md
# packet_rr_arbiter

Round-robin, packet-granular arbiter that shares one downstream stream port among SIZE requesters. It issues a registered one-hot grant plus its binary index for the output mux select, holds the grant until the granted packet's last beat transfers, then rotates priority. It also force-releases a grant that stalls beyond a programmable idle limit. It sits in front of the stream mux in crossbar and muxing datapaths, replacing fixed-priority selection.

## Interface
- SIZE, 4: number of requesters; power of two, 2..256.
- IDX_W, log2(SIZE): width of grant_idx; derived, not overridden.
- TIMEOUT, 0: idle cycles allowed while granted before forced release; 0 disables the watchdog; max 2^16-1.
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  synchronous, active-high; full reinit.
- clear  input  1  synchronous, active-high; same effect as reset.
- req  input  SIZE  per-requester request (that input's tvalid).
- beat  input  1  one beat transferred on the output port (out tvalid & tready).
- last  input  1  tlast of the current output beat; qualified by beat.
- grant  output  SIZE  one-hot grant; all-zero when idle.
- grant_idx  output  IDX_W  binary index of the granted requester; 0 when idle.
- grant_valid  output  1  a grant is active.
- timeout  output  1  one-cycle pulse on forced release.

## Operation
- States: IDLE and BUSY. Priority pointer ptr, width IDX_W; ptr is the highest-priority requester index.
- Selection: the first asserted req at index ptr, ptr+1, ..., wrapping mod SIZE.
- IDLE:
  - With no req: stay in IDLE; outputs at their reset values.
  - With any req: register the selected requester k into grant, grant_idx and grant_valid; go to BUSY; set ptr to k+1 mod SIZE.
- BUSY:
  - The grant is frozen. Changes on req, including deassertion of req[k], do not alter it.
  - beat without last: no state change. last without beat: ignored.
  - beat and last, with any req asserted in that cycle: select from the current req using the updated ptr and register the new grant. No idle bubble. The just-served requester has lowest priority but is re-granted if it is the only requester.
  - beat and last, with no req: return to IDLE.
- Watchdog (TIMEOUT > 0):
  - A 16-bit counter increments each BUSY cycle without beat.
  - The counter zeroes on beat, on grant change, and in IDLE.
  - When the counter reaches TIMEOUT, pulse timeout and release exactly as for beat and last: re-arbitrate, or go to IDLE.
  - When TIMEOUT = 0, the counter is held at zero and timeout stays 0.
- Invariants:
  - grant is zero or one-hot.
  - grant[grant_idx] == grant_valid.
  - grant_idx is the binary encoding of grant.
- Reset or clear, any cycle including mid-packet:
  - State IDLE, ptr=0, counter=0.
  - grant=0, grant_idx=0, grant_valid=0, timeout=0.
  - An in-flight packet is abandoned; upstream handles realignment.

## Timing
- Grant latency: req sampled in IDLE at cycle t yields grant_valid=1 at cycle t+1.
- Handover: beat and last at cycle t yields the new grant (or idle) at t+1. Sustained back-to-back packets see zero dead cycles.
- The downstream mux uses grant_idx from the same cycle. The arbiter may be pipelined only before its registered outputs.
- A timeout pulse at cycle t+1 coincides with the updated grant.
- All outputs are registered. No combinational path from inputs to outputs.

## Test plan
- Reset: assert reset with req=4'b1111 for 3 cycles -> grant=0, grant_idx=0, grant_valid=0, timeout=0 throughout. Release reset -> grant=4'b0001 one cycle later.
- Rotation: hold req=4'b1111 and send 1-beat packets (beat=last=1) every cycle -> grant_idx sequence 0,1,2,3,0 with grant_valid continuously 1.
- Sparse/wrap: ptr=3 (after serving 2), req=4'b0011 -> grant_idx=0. Then req=4'b0001 alone -> 0 is re-granted after its last beat.
- Frozen grant: grant_idx=1, 5-beat packet; toggle req[1] low and req[2] high mid-packet -> grant holds 4'b0010 until the cycle after the 5th beat with last. Beat with last=0, and last without beat, leave it unchanged.
- Watchdog: TIMEOUT=8, grant on 2, no beats -> timeout pulses exactly 8 BUSY cycles after the grant. Grant moves to the next requester or IDLE in the same cycle. A single beat at cycle 7 restarts the count.
- Clear mid-packet: clear during beat 2 of a 4-beat packet on requester 3 -> next cycle is IDLE. With req=4'b1000 held -> grant_idx=3 again, since ptr=0 and no other request is pending.
